mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer for a small word-addressed memory array built from the team's 8-bit mem_word blocks.
- Each requester issues a single read or write. The block grants one requester and drives per-word sel and the shared rw/data lines with latch-safe setup/enable/hold timing.
- It captures and re-inverts read data, then returns a one-cycle valid pulse to the winning requester.

Parameters:
- NUM_WORDS, 4, number of mem_word instances served (1..2**ADDR_W).
- ADDR_W, 2, requester address width.
- DATA_W, 8, word width.
- WRITE_CYCLES, 2, cycles the latch enable (rw&sel) is held high during a write (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0, req1  in  1  access request from requester 0 / 1.
- op0, op1  in  1  1 = write, 0 = read.
- addr0, addr1  in  ADDR_W  word address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  one-cycle grant; the request fields have been captured.
- valid0, valid1  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read result, held until the next read completes.
- mem_sel  out  NUM_WORDS  one-hot word select.
- mem_rw  out  1  shared write enable to all words.
- mem_wdata  out  DATA_W  shared write data.
- mem_rdata  in  NUM_WORDS*DATA_W  concatenated word outputs; word i at [i*DATA_W +: DATA_W]. A selected word outputs inverted stored data; an unselected word outputs all ones.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State IDLE, round-robin pointer at 0.
  - gnt*, valid*, mem_sel, mem_rw all 0; mem_wdata = 0; rdata = 0.
  - A write interrupted by reset leaves that word's contents undefined. No other word is disturbed.
- States: IDLE, SETUP, WRITE, HOLD, READ, RESP.
- IDLE:
  - At a rising edge with any req high, pick the winner.
  - If only one requester is asking, it wins. If both are asking, the requester named by the pointer wins.
  - Capture the winner's op, addr and wdata, flip the pointer to the loser, and go to SETUP.
- SETUP (1 cycle):
  - gnt of the winner = 1.
  - mem_sel[addr] = 1, mem_rw = 0, mem_wdata = captured data.
  - Next state is WRITE if op = 1, else READ.
- WRITE (WRITE_CYCLES cycles): mem_sel[addr] = 1, mem_rw = 1, mem_wdata held. Then go to HOLD.
- HOLD (1 cycle): mem_rw = 0, mem_sel[addr] and mem_wdata still held so the latch closes on stable data. Then go to RESP.
- READ (1 cycle):
  - mem_sel[addr] = 1, mem_rw = 0.
  - At the closing edge, rdata <= bitwise NOT of word addr's slice of mem_rdata.
  - Then go to RESP.
- RESP (1 cycle):
  - valid of the winner = 1; mem_sel = 0, mem_rw = 0.
  - rdata is updated only after a read; a write leaves it unchanged.
  - Return to IDLE.
- Latency, counted from the IDLE sampling edge E0:
  - gnt is high in cycle 1.
  - A read has valid in cycle 3.
  - A write has valid in cycle 3+WRITE_CYCLES, which is cycle 5 at the default.
- Handshake:
  - Request fields are sampled only at the IDLE decision edge. Requesters may change them after gnt.
  - req still high in IDLE after valid is treated as a new request. Back-to-back requests are arbitrated fresh.
  - A request arriving while busy waits; it is never dropped while req is held.
- Fairness: with both req held continuously, grants alternate 0,1,0,1…
- Out-of-range address (addr >= NUM_WORDS):
  - No mem_sel bit is asserted and mem_rw stays 0.
  - A read returns rdata = 0. The normal state sequence and valid pulse still occur.
- Invariants:
  - At most one mem_sel bit is high at any time.
  - mem_rw is high only in WRITE, and only while mem_sel is high.
  - gnt0&gnt1 and valid0&valid1 are never both high.

Decomposition:
- Package mem_arbiter_pkg holds:
  - the state enum (IDLE, SETUP, WRITE, HOLD, READ, RESP);
  - OP_READ = 0 and OP_WRITE = 1;
  - the default width constants.
- Sub-module mem_arbiter_rr: the 2-way round-robin pick plus pointer register.
  - Inputs: clk, reset, req0, req1, advance.
  - Outputs: winner, any_req.
- The sequencer, capture registers and read-data mux stay in mem_arbiter.

Test Plan:
- Write then read: req0 writes 0xA5 to addr 2, then req0 reads addr 2, using a 4× mem_word model.
  - Expect gnt0 in cycle 1 and valid0 in cycle 5 for the write.
  - Expect valid0 in cycle 3 of the read with rdata = 0xA5.
  - No other word changes.
- Simultaneous requests after reset: req0 and req1 high together, held for 4 transactions.
  - Expect the grant order 0,1,0,1 and never both gnt.
- Latch timing check: during a write, assert mem_rw rises only after a cycle with sel=1 and rw=0, and falls a cycle before sel falls.
  - mem_wdata must be stable for the whole window.
- Out-of-range address with NUM_WORDS = 3: read addr 3.
  - mem_sel stays 0 throughout; rdata = 0x00; valid pulses in cycle 3.
- Reset mid-write: assert reset low during WRITE.
  - mem_rw, mem_sel, gnt* and valid* go to 0 immediately, without waiting for a clock edge.
  - After release the state is IDLE and a new read of another word returns its prior value.
- Waiting requester: req1 rises while the req0 transaction is in progress.
  - Expect gnt1 exactly one cycle after the IDLE edge that follows valid0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned NUM_WORDS_DEF    = 4;
    localparam int unsigned ADDR_W_DEF       = 2;
    localparam int unsigned DATA_W_DEF       = 8;
    localparam int unsigned WRITE_CYCLES_DEF = 2;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        HOLD,
        READ,
        RESP
    } state_e;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin pick; the pointer names the requester favoured on a tie.
module mem_arbiter_rr (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic winner,
    output logic any_req
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        any_req = req0 | req1;
        winner  = (req0 && req1) ? ptr_q : req1;
        ptr_d   = advance ? ~winner : ptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and latch-safe access sequencer for an array of mem_word blocks.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned NUM_WORDS    = NUM_WORDS_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned WRITE_CYCLES = WRITE_CYCLES_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req0,
    input  logic                        req1,
    input  logic                        op0,
    input  logic                        op1,
    input  logic [ADDR_W-1:0]           addr0,
    input  logic [ADDR_W-1:0]           addr1,
    input  logic [DATA_W-1:0]           wdata0,
    input  logic [DATA_W-1:0]           wdata1,
    output logic                        gnt0,
    output logic                        gnt1,
    output logic                        valid0,
    output logic                        valid1,
    output logic [DATA_W-1:0]           rdata,
    output logic [NUM_WORDS-1:0]        mem_sel,
    output logic                        mem_rw,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [NUM_WORDS*DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
    localparam logic [ADDR_W:0] NW_LIM = (ADDR_W+1)'(NUM_WORDS);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                win_q, win_d;
    logic                op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [NUM_WORDS-1:0] sel_q, sel_d;
    logic                rw_q, rw_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                valid0_q, valid0_d, valid1_q, valid1_d;

    logic                advance;
    logic                winner;
    logic                any_req;
    logic                in_range_d;
    logic                active_d;
    logic [DATA_W-1:0]   rd_word;

    mem_arbiter_rr u_rr (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .advance (advance),
        .winner  (winner),
        .any_req (any_req)
    );

    // Next state, capture registers and the registered bus image for the coming cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        advance  = 1'b0;
        rd_word  = '1;

        // Unselected or missing words read as all ones, so out-of-range reads invert to zero.
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                rd_word = mem_rdata[i*DATA_W +: DATA_W];
            end
        end

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    advance = 1'b1;
                    win_d   = winner;
                    op_d    = winner ? op1    : op0;
                    addr_d  = winner ? addr1  : addr0;
                    wdata_d = winner ? wdata1 : wdata0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = (op_q == OP_WRITE) ? WRITE : READ;
            end
            WRITE: begin
                if (cnt_q == CNT_W'(WRITE_CYCLES - 1)) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD:    state_d = RESP;
            READ: begin
                rdata_d = ~rd_word;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_range_d = ({1'b0, addr_d} < NW_LIM);
        active_d   = state_d inside {SETUP, WRITE, HOLD, READ};
        sel_d      = (active_d && in_range_d) ? (NUM_WORDS'(1) << addr_d) : '0;
        rw_d       = (state_d == WRITE) && in_range_d;
        gnt0_d     = (state_d == SETUP) && !win_d;
        gnt1_d     = (state_d == SETUP) &&  win_d;
        valid0_d   = (state_d == RESP)  && !win_d;
        valid1_d   = (state_d == RESP)  &&  win_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            win_q    <= 1'b0;
            op_q     <= OP_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            sel_q    <= '0;
            rw_q     <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            sel_q    <= sel_d;
            rw_q     <= rw_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign valid0    = valid0_q;
    assign valid1    = valid1_q;
    assign rdata     = rdata_q;
    assign mem_sel   = sel_q;
    assign mem_rw    = rw_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-timeline model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int NW = 4;
    localparam int DW = 8;
    localparam int WC = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [1:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;

    logic gnt0, gnt1, valid0, valid1, mem_rw;
    logic [7:0] rdata, mem_wdata;
    logic [3:0] mem_sel;
    logic [31:0] mem_rdata;

    logic gnt0_3, gnt1_3, valid0_3, valid1_3, mem_rw3;
    logic [7:0] rdata3, mem_wdata3;
    logic [2:0] mem_sel3;
    logic [23:0] mem_rdata3;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_WORDS(4), .ADDR_W(2), .DATA_W(8), .WRITE_CYCLES(WC)) u_dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1), .rdata(rdata),
        .mem_sel(mem_sel), .mem_rw(mem_rw), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.NUM_WORDS(3), .ADDR_W(2), .DATA_W(8), .WRITE_CYCLES(WC)) u_dut3 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_3), .gnt1(gnt1_3), .valid0(valid0_3), .valid1(valid1_3), .rdata(rdata3),
        .mem_sel(mem_sel3), .mem_rw(mem_rw3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    // mem_word arrays: latch writes while sel&rw, selected word drives inverted data
    logic [7:0] phys[NW] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] phys3[3] = '{8'h55, 8'h66, 8'h77};

    always @(posedge clk) begin
        for (int i = 0; i < NW; i++) if (mem_sel[i] && mem_rw) phys[i] <= mem_wdata;
        for (int i = 0; i < 3; i++) if (mem_sel3[i] && mem_rw3) phys3[i] <= mem_wdata3;
    end

    always_comb begin
        mem_rdata  = '1;
        mem_rdata3 = '1;
        for (int i = 0; i < NW; i++) if (mem_sel[i]) mem_rdata[i*DW +: DW] = ~phys[i];
        for (int i = 0; i < 3; i++) if (mem_sel3[i]) mem_rdata3[i*DW +: DW] = ~phys3[i];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction is a timeline of cycles 1..len after the decision edge
    bit         m_busy = 0, m_win = 0, m_op = 0, m_ptr = 0, m_rd_known = 1;
    int         m_k = 0, m_len = 0;
    logic [1:0] m_addr = '0;
    logic [7:0] m_wdata = '0, m_rdata = '0;
    logic [7:0] m_mem[NW] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bit         m_known[NW] = '{1, 1, 1, 1};

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            if (m_busy && m_op) m_known[m_addr] = 0;
            m_busy = 0; m_k = 0; m_ptr = 0; m_rdata = '0; m_rd_known = 1; m_wdata = '0;
        end else if (m_busy) begin
            if (!m_op && m_k == 2) begin
                m_rdata = m_mem[m_addr];
                m_rd_known = m_known[m_addr];
            end
            if (m_k == m_len) begin
                m_busy = 0;
                if (m_op) begin
                    m_mem[m_addr] = m_wdata;
                    m_known[m_addr] = 1;
                end
            end else begin
                m_k++;
            end
        end else if (req0 || req1) begin
            m_win   = (req0 && req1) ? m_ptr : req1;
            m_ptr   = !m_win;
            m_op    = m_win ? op1 : op0;
            m_addr  = m_win ? addr1 : addr0;
            m_wdata = m_win ? wdata1 : wdata0;
            m_len   = m_op ? 3 + WC : 3;
            m_k     = 1;
            m_busy  = 1;
        end
    end

    bit chk_en = 0;
    logic e_g0, e_g1, e_v0, e_v1, e_rw, p_rw = 1'b0;
    logic [3:0] e_sel, one = 4'b0001, p_sel = '0;
    logic [7:0] p_wd = '0;

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            e_g0  = m_busy && m_k == 1 && !m_win;
            e_g1  = m_busy && m_k == 1 &&  m_win;
            e_v0  = m_busy && m_k == m_len && !m_win;
            e_v1  = m_busy && m_k == m_len &&  m_win;
            e_sel = (m_busy && m_k < m_len) ? (one << m_addr) : 4'b0;
            e_rw  = m_busy && m_op && m_k >= 2 && m_k <= 1 + WC;
            chk("gnt0", 32'(gnt0), 32'(e_g0));
            chk("gnt1", 32'(gnt1), 32'(e_g1));
            chk("valid0", 32'(valid0), 32'(e_v0));
            chk("valid1", 32'(valid1), 32'(e_v1));
            chk("mem_sel", 32'(mem_sel), 32'(e_sel));
            chk("mem_rw", 32'(mem_rw), 32'(e_rw));
            if (e_sel != 4'b0) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            if (m_rd_known) chk("rdata", 32'(rdata), 32'(m_rdata));
            if (!m_busy)
                for (int i = 0; i < NW; i++) if (m_known[i]) chk("mem_word", 32'(phys[i]), 32'(m_mem[i]));
            if (mem_rw && !p_rw) chk("rw_setup", 32'(p_sel == mem_sel && mem_sel != 4'b0), 32'd1);
            if (!mem_rw && p_rw) chk("rw_hold_sel", 32'(mem_sel), 32'(p_sel));
            if (mem_sel != 4'b0 && mem_sel == p_sel) chk("wdata_stable", 32'(mem_wdata), 32'(p_wd));
        end
        p_rw  = mem_rw;
        p_sel = mem_sel;
        p_wd  = mem_wdata;
    end

    int gc, vc, vc3, gc1, ng;
    int order[4];
    logic [2:0] s3;
    bit done;

    // Single request from one requester; reports grant/valid cycles counted from the decision edge.
    task automatic txn(input bit who, input bit op, input logic [1:0] a, input logic [7:0] wd);
        gc = -1; vc = -1; vc3 = -1; s3 = '0;
        if (who) begin req1 = 1'b1; op1 = op; addr1 = a; wdata1 = wd; end
        else     begin req0 = 1'b1; op0 = op; addr0 = a; wdata0 = wd; end
        for (int c = 1; c <= 20 && vc < 0; c++) begin
            @(negedge clk);
            s3 |= mem_sel3;
            if ((who ? gnt1 : gnt0) && gc < 0) begin
                gc = c;
                if (who) req1 = 1'b0; else req0 = 1'b0;
            end
            if (who ? valid1_3 : valid0_3) vc3 = c;
            if (who ? valid1 : valid0) vc = c;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ctl", 32'({gnt0, gnt1, valid0, valid1, mem_rw}), 32'd0);
        chk("rst_sel", 32'(mem_sel), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        reset = 1'b1;
        chk_en = 1;

        // Both held from reset: grants must alternate starting with requester 0
        req0 = 1'b1; op0 = OP_READ; addr0 = 2'd0;
        req1 = 1'b1; op1 = OP_READ; addr1 = 2'd1;
        ng = 0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk);
            if (gnt0) begin order[ng] = 0; ng++; end
            else if (gnt1) begin order[ng] = 1; ng++; end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));

        repeat (400) begin
            @(negedge clk);
            req0   = ($urandom_range(0, 2) != 0);
            req1   = ($urandom_range(0, 2) != 0);
            op0    = 1'($urandom);
            op1    = 1'($urandom);
            addr0  = 2'($urandom);
            addr1  = 2'($urandom);
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (10) @(negedge clk);

        txn(0, OP_WRITE, 2'd2, 8'hA5);
        chk("wr_gnt_cyc", 32'(gc), 32'd1);
        chk("wr_valid_cyc", 32'(vc), 32'd5);
        txn(0, OP_READ, 2'd2, 8'h00);
        chk("rd_gnt_cyc", 32'(gc), 32'd1);
        chk("rd_valid_cyc", 32'(vc), 32'd3);
        chk("rd_data", 32'(rdata), 32'hA5);
        chk("rd_data3", 32'(rdata3), 32'hA5);

        txn(1, OP_WRITE, 2'd0, 8'h3C);
        txn(1, OP_READ, 2'd0, 8'h00);
        chk("rd3_w0", 32'(rdata3), 32'h3C);
        txn(1, OP_READ, 2'd3, 8'h00);
        chk("oor_sel", 32'(s3), 32'd0);
        chk("oor_rdata", 32'(rdata3), 32'd0);
        chk("oor_valid_cyc", 32'(vc3), 32'd3);

        // req1 arrives mid-transaction and must be granted right after the following IDLE edge
        req0 = 1'b1; op0 = OP_READ; addr0 = 2'd1;
        gc1 = -1; done = 0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (c == 2) begin req1 = 1'b1; op1 = OP_READ; addr1 = 2'd3; end
            if (gnt0) req0 = 1'b0;
            if (gnt1 && gc1 < 0) begin gc1 = c; req1 = 1'b0; end
            if (valid1) done = 1;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("wait_gnt1_cyc", 32'(gc1), 32'd5);

        // Reset lands in the middle of a write to word 1
        req0 = 1'b1; op0 = OP_WRITE; addr0 = 2'd1; wdata0 = 8'h77;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        chk("mid_rw_before", 32'(mem_rw), 32'd1);
        chk_en = 0;
        #2 reset = 1'b0;
        #1;
        chk("arst_rw", 32'(mem_rw), 32'd0);
        chk("arst_sel", 32'(mem_sel), 32'd0);
        chk("arst_gv", 32'({gnt0, gnt1, valid0, valid1}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1;
        txn(0, OP_READ, 2'd2, 8'h00);
        chk("post_rst_valid_cyc", 32'(vc), 32'd3);
        chk("post_rst_rdata", 32'(rdata), 32'hA5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
